// File: rtl/lfsr_step_scheduler.sv
// lfsr_step_scheduler: issues seed-load and step enable pulses for the LFSR from start/stop/burst/step commands
module lfsr_step_scheduler #(
  parameter int RATE0_DIV = 1000000,
  parameter int RATE1_DIV = 10000000,
  parameter int RATE2_DIV = 50000000,
  parameter int RATE3_DIV = 100000000,
  parameter int CNT_W     = 27
) (
  input  logic        clk_in,
  input  logic        rst_n,
  input  logic        cmd_start,
  input  logic        cmd_stop,
  input  logic        cmd_burst,
  input  logic        cmd_step,
  input  logic [7:0]  burst_len,
  input  logic [1:0]  rate_sel,
  output logic        lfsr_seed_load,
  output logic        lfsr_step,
  output logic        busy,
  output logic [1:0]  state,
  output logic [15:0] step_count
);
  typedef enum logic [1:0] {IDLE, LOAD, RUN, BURST} state_t;
  state_t           r_state;
  logic             r_mode;
  logic [1:0]       r_rate;
  logic [CNT_W-1:0] r_div;
  logic [7:0]       r_rem;
  logic [CNT_W-1:0] w_div_max;
  logic             w_tc;
  always_comb begin
    w_div_max = r_rate == 2'd0 ? CNT_W'(RATE0_DIV - 1) :
                r_rate == 2'd1 ? CNT_W'(RATE1_DIV - 1) :
                r_rate == 2'd2 ? CNT_W'(RATE2_DIV - 1) : CNT_W'(RATE3_DIV - 1);
    w_tc = r_div == w_div_max;
  end
  assign state = r_state;
  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      r_state        <= IDLE;
      r_mode         <= 1'b0;
      r_rate         <= 2'd0;
      r_div          <= '0;
      r_rem          <= 8'd0;
      lfsr_seed_load <= 1'b0;
      lfsr_step      <= 1'b0;
      busy           <= 1'b0;
      step_count     <= 16'd0;
    end else begin
      lfsr_seed_load <= 1'b0;
      lfsr_step      <= 1'b0;
      case (r_state)
        IDLE: begin
          if (cmd_start || (cmd_burst && burst_len != 8'd0)) begin
            r_state        <= LOAD;
            busy           <= 1'b1;
            r_mode         <= !cmd_start;
            r_rem          <= burst_len;
            r_rate         <= rate_sel;
            r_div          <= '0;
            lfsr_seed_load <= 1'b1;
            step_count     <= 16'd0;
          end else if (cmd_step) begin
            lfsr_step  <= 1'b1;
            step_count <= step_count + 16'd1;
          end
        end
        LOAD: begin
          r_div <= '0;
          if (cmd_stop) begin
            r_state <= IDLE;
            busy    <= 1'b0;
          end else begin
            r_state <= r_mode ? BURST : RUN;
          end
        end
        default: begin
          // stop beats a coincident terminal count, so no step escapes an abort
          if (cmd_stop) begin
            r_state <= IDLE;
            busy    <= 1'b0;
            r_div   <= '0;
          end else if (w_tc) begin
            r_div      <= '0;
            lfsr_step  <= 1'b1;
            step_count <= step_count + 16'd1;
            if (r_state == BURST) begin
              r_rem <= r_rem - 8'd1;
              if (r_rem == 8'd1) begin
                r_state <= IDLE;
                busy    <= 1'b0;
              end
            end
          end else begin
            r_div <= r_div + 1'b1;
          end
        end
      endcase
    end
  end
endmodule

// File: doc/lfsr_step_scheduler.md
Name: lfsr_step_scheduler

Overview:
- Sequences the LFSR datapath on the Basys3 board by issuing single-cycle clock-enable pulses in the 100 MHz domain. It replaces the toggled slow clock with an enable.
- It provides one-shot seed load, free-run, fixed-length burst and single-step modes, with four selectable step rates.
- It sits between the button/switch front end (commands arrive as already-debounced one-cycle pulses) and the LFSR register plus its display logic.

Parameters:
- RATE0_DIV, 1000000, cycles between steps for rate_sel=0 (100 Hz at 100 MHz).
- RATE1_DIV, 10000000, cycles between steps for rate_sel=1 (10 Hz).
- RATE2_DIV, 50000000, cycles between steps for rate_sel=2 (2 Hz).
- RATE3_DIV, 100000000, cycles between steps for rate_sel=3 (1 Hz).
- CNT_W, 27, divider counter width. Must hold the largest RATEn_DIV-1.

Ports:
- clk_in  input  1  100 MHz board clock.
- rst_n  input  1  asynchronous reset, active low.
- cmd_start  input  1  one-cycle pulse: seed and begin free-run.
- cmd_stop  input  1  one-cycle pulse: abort run or burst.
- cmd_burst  input  1  one-cycle pulse: seed and run burst_len steps.
- cmd_step  input  1  one-cycle pulse: single immediate step (IDLE only).
- burst_len  input  8  number of steps for a burst.
- rate_sel  input  2  step-rate select.
- lfsr_seed_load  output  1  one-cycle pulse: LFSR loads its seed.
- lfsr_step  output  1  one-cycle pulse: LFSR advances one step.
- busy  output  1  high when state is not IDLE.
- state  output  2  current state encoding.
- step_count  output  16  number of lfsr_step pulses since the last seed load.

Behaviour:
- Single clock domain, clk_in. Every output is registered.
- Reset (rst_n low) is asynchronous. Reset values: state=IDLE, divider counter=0, remaining-step counter=0, lfsr_seed_load=0, lfsr_step=0, busy=0, step_count=0. Reset mid-run or mid-burst aborts immediately with no further pulses.
- States: IDLE=0, LOAD=1, RUN=2, BURST=3.
- IDLE, command priority is start > burst > step:
  - cmd_start → LOAD, mode=RUN.
  - cmd_burst with burst_len≠0 → LOAD, mode=BURST, burst_len latched.
  - cmd_burst with burst_len=0 → ignored, no pulse.
  - cmd_step → lfsr_step high for exactly the next cycle; state stays IDLE.
  - cmd_stop → no effect.
- Latching: rate_sel is latched on the IDLE→LOAD transition. Changes to rate_sel outside that transition are ignored until the next start or burst.
- LOAD (exactly one cycle):
  - lfsr_seed_load=1 and step_count cleared to 0 in the same cycle.
  - Divider counter cleared.
  - Next state is RUN or BURST per the latched mode.
  - Commands arriving during LOAD are ignored, except cmd_stop, which sends the next state to IDLE with no step issued.
- Divider in RUN/BURST:
  - The counter increments each cycle.
  - When count==DIVsel-1: counter→0 and lfsr_step=1 in the following cycle.
  - The first step pulse occurs DIVsel cycles after the first RUN/BURST cycle; thereafter one pulse every DIVsel cycles.
  - cmd_start, cmd_burst and cmd_step are ignored in these states.
- RUN: continues indefinitely. cmd_stop → IDLE next cycle, counter cleared. If cmd_stop coincides with the terminal count, stop wins and no step is issued.
- BURST:
  - The remaining-step counter decrements on each issued step.
  - The step issued when remaining==1 is the last one; state→IDLE in the same cycle that last lfsr_step is high.
  - Exactly burst_len pulses are issued.
  - cmd_stop aborts with the same rule as RUN.
- step_count:
  - +1 on every lfsr_step pulse, including IDLE single steps.
  - Wraps from 0xFFFF to 0x0000.
  - Cleared only by reset or lfsr_seed_load.
- lfsr_seed_load and lfsr_step are never high in the same cycle.
- busy is a registered decode of state, so it equals (state≠IDLE) cycle-for-cycle.

Test Plan:
- Bench parameters: RATE0..3_DIV = 4/8/16/32.
- Reset release, no commands for 100 cycles → all outputs 0, state=0.
- rate_sel=1, cmd_start at cycle t:
  - seed_load high at t+1; state=2 from t+2.
  - lfsr_step high at t+10, t+18, t+26.
  - cmd_stop at t+30 → state=0 at t+31; step_count=3; no further steps.
- rate_sel=0, burst_len=5, cmd_burst:
  - exactly 5 step pulses, 4 cycles apart; busy drops with the 5th pulse; step_count=5.
  - Repeat with burst_len=0 → no seed_load, state stays 0.
- cmd_start and cmd_step in the same cycle → start wins; no immediate step. Change rate_sel mid-run → period unchanged.
- In IDLE, 3 cmd_step pulses spaced 2 cycles apart → 3 one-cycle steps each 1 cycle after its command; step_count=3. Then cmd_start → step_count clears at the seed_load cycle.
- Run at rate_sel=3. Assert cmd_stop on the terminal-count cycle → no step issued. Assert rst_n low asynchronously mid-burst → outputs 0 immediately, no step pulses during or after reset.
- step_count wrap: preload via 65536 IDLE steps (or force) → value 0xFFFF followed by 0x0000.
